// File: rtl/inst_mem_pkg.sv
// Shared constants for the instruction fetch memory: fill word, fault codes and FSM states.
// Pure definitions; no timing or flow-control behaviour of its own.
package inst_mem_pkg;

   localparam logic [31:0] NOP_WORD       = 32'h00000013;

   localparam logic [1:0]  FAULT_NONE     = 2'b00;
   localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
   localparam logic [1:0]  FAULT_RANGE    = 2'b10;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

endpackage

// File: rtl/inst_mem_fetch_array.sv
// DEPTH x 32 storage: one synchronous write port, one registered read port returning pre-write data.
// Read data appears one cycle after re and holds while re is low; there is no backpressure.
module inst_mem_array
   import inst_mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic             re,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_idx] <= wr_data;
   end

   // Same-edge write and read of one word returns the old contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else if (re)
         rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/inst_mem_fetch.sv
// Instruction memory with valid/ready fetch port, program port and post-reset NOP fill.
// Latency 1 cycle accept-to-response; req_ready drops while a held response is not taken.
module inst_mem_fetch #(
   parameter int          PC_W     = 64,
   parameter int          DEPTH    = 256,
   parameter int          IDX_W    = $clog2(DEPTH),
   parameter logic [31:0] NOP_WORD = inst_mem_pkg::NOP_WORD
) (
   input  logic             clk,
   input  logic             reset,
   output logic             init_done,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [PC_W-1:0]  req_pc,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_instr,
   output logic [1:0]       resp_fault,
   input  logic             prog_we,
   input  logic [IDX_W-1:0] prog_idx,
   input  logic [31:0]      prog_data
);
   import inst_mem_pkg::*;

   state_t           state;
   logic [IDX_W-1:0] fill_cnt;
   logic [1:0]       req_fault;
   logic             accept;
   logic             mem_we;
   logic [IDX_W-1:0] mem_wr_idx;
   logic [31:0]      mem_wr_data;
   logic [31:0]      rd_data;

   assign req_ready = (state == ST_IDLE) || ((state == ST_BUSY) && resp_ready);
   assign accept    = req_valid && req_ready;

   // Misalignment wins; with DEPTH a power of two, any set bit above the index is out of range.
   always_comb begin
      req_fault = FAULT_NONE;
      if (req_pc[1:0] != 2'b00)
         req_fault = FAULT_MISALIGN;
      else if (req_pc[PC_W-1:IDX_W+2] != '0)
         req_fault = FAULT_RANGE;
   end

   always_comb begin
      mem_we      = 1'b0;
      mem_wr_idx  = prog_idx;
      mem_wr_data = prog_data;
      if (state == ST_INIT) begin
         mem_we      = 1'b1;
         mem_wr_idx  = fill_cnt;
         mem_wr_data = NOP_WORD;
      end else if (prog_we) begin
         mem_we      = 1'b1;
      end
   end

   inst_mem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .we      (mem_we),
      .wr_idx  (mem_wr_idx),
      .wr_data (mem_wr_data),
      .re      (accept && (req_fault == FAULT_NONE)),
      .rd_idx  (req_pc[IDX_W+1:2]),
      .rd_data (rd_data)
   );

   // Faulted fetches never touch the read register, so the NOP is substituted here.
   assign resp_instr = (resp_fault == FAULT_NONE) ? rd_data : NOP_WORD;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_INIT;
         fill_cnt   <= '0;
         init_done  <= 1'b0;
         resp_valid <= 1'b0;
         resp_fault <= FAULT_NONE;
      end else begin
         case (state)
            ST_INIT: begin
               fill_cnt <= fill_cnt + 1'b1;
               if (fill_cnt == IDX_W'(DEPTH - 1)) begin
                  state     <= ST_IDLE;
                  init_done <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  state      <= ST_BUSY;
                  resp_valid <= 1'b1;
                  resp_fault <= req_fault;
               end
            end
            ST_BUSY: begin
               if (accept) begin
                  resp_fault <= req_fault;
               end else if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch: expected responses queued at issue, checked at the handshake.
module tb_inst_mem_fetch;

   localparam int          PC_W  = 64;
   localparam int          DEPTH = 256;
   localparam int          IDX_W = 8;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic             clk;
   logic             reset;
   logic             init_done;
   logic             req_valid;
   logic             req_ready;
   logic [PC_W-1:0]  req_pc;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_instr;
   logic [1:0]       resp_fault;
   logic             prog_we;
   logic [IDX_W-1:0] prog_idx;
   logic [31:0]      prog_data;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [33:0] exp_q[$];

   inst_mem_fetch #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .init_done  (init_done),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pc     (req_pc),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_fault (resp_fault),
      .prog_we    (prog_we),
      .prog_idx   (prog_idx),
      .prog_data  (prog_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Scoreboard: a response is consumed when seen with resp_ready high before the edge.
   always @(negedge clk) begin
      logic [33:0] e;
      if (!reset && resp_valid && resp_ready) begin
         chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_instr", resp_instr, e[33:2]);
            chk("sb_fault", resp_fault, e[1:0]);
         end
      end
   end

   task automatic issue(input logic [63:0] pc, input logic [31:0] ei, input logic [1:0] ef,
                        output int waited);
      logic acc;
      acc       = 1'b0;
      waited    = 0;
      req_valid = 1'b1;
      req_pc    = pc;
      exp_q.push_back({ei, ef});
      while (!acc && waited < 64) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      req_valid = 1'b0;
      chk("accept", acc, 1);
      if (acc) chk("latency", resp_valid, 1);
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 64) begin
         @(posedge clk);
         #1;
         i++;
      end
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input logic [IDX_W-1:0] idx, input logic [31:0] data);
      prog_we   = 1'b1;
      prog_idx  = idx;
      prog_data = data;
      @(posedge clk);
      #1;
      prog_we   = 1'b0;
   endtask

   task automatic wait_init(output int cnt);
      cnt = 0;
      while (!init_done && cnt < 400) begin
         @(posedge clk);
         #1;
         cnt++;
         prog_we = (cnt == 100);
         if (cnt == 100) begin
            prog_idx  = '0;
            prog_data = 32'h11111111;
         end
         if (cnt == 50) chk("ready_in_init", req_ready, 0);
      end
      prog_we = 1'b0;
   endtask

   initial begin
      int w;
      int cnt;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_pc     = '0;
      resp_ready = 1'b1;
      prog_we    = 1'b0;
      prog_idx   = '0;
      prog_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_init_done", init_done, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_instr", resp_instr, 0);
      chk("rst_resp_fault", resp_fault, 0);
      chk("rst_req_ready", req_ready, 0);

      // Fill; a program write late in INIT must be ignored.
      reset = 1'b0;
      wait_init(cnt);
      chk("fill_cycles", cnt, DEPTH);
      issue(64'h0, NOP, 2'b00, w);
      issue(64'h3FC, NOP, 2'b00, w);
      drain();

      prog(8'd0, 32'h00940333);
      prog(8'd1, 32'h413903b3);
      issue(64'h0, 32'h00940333, 2'b00, w);
      chk("b2b_first_wait", w, 1);
      issue(64'h4, 32'h413903b3, 2'b00, w);
      chk("b2b_second_wait", w, 1);
      drain();

      // Backpressure with a queued request behind the held response.
      resp_ready = 1'b0;
      issue(64'h4, 32'h413903b3, 2'b00, w);
      req_valid = 1'b1;
      req_pc    = 64'h0;
      exp_q.push_back({32'h00940333, 2'b00});
      repeat (3) begin
         @(negedge clk);
         chk("bp_valid", resp_valid, 1);
         chk("bp_instr", resp_instr, 32'h413903b3);
         chk("bp_ready", req_ready, 0);
         @(posedge clk);
         #1;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", req_ready, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("bp_new_instr", resp_instr, 32'h00940333);
      drain();

      issue(64'h2, NOP, 2'b01, w);
      issue(64'h400, NOP, 2'b10, w);
      issue(64'h1_0000_0002, NOP, 2'b01, w);
      issue(64'h1_0000_0000, NOP, 2'b10, w);
      issue(64'h4, 32'h413903b3, 2'b00, w);
      drain();

      // Write and fetch of word 2 on the same edge.
      prog_we   = 1'b1;
      prog_idx  = 8'd2;
      prog_data = 32'hDEADBEEF;
      issue(64'h8, NOP, 2'b00, w);
      chk("collide_wait", w, 1);
      prog_we = 1'b0;
      issue(64'h8, 32'hDEADBEEF, 2'b00, w);
      drain();

      // Reset while a response is held.
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_pc     = 64'h0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("pre_reset_valid", resp_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_resp_valid", resp_valid, 0);
      chk("async_init_done", init_done, 0);
      chk("async_req_ready", req_ready, 0);
      @(posedge clk);
      #1;
      reset      = 1'b0;
      resp_ready = 1'b1;
      wait_init(cnt);
      chk("refill_cycles", cnt, DEPTH);
      issue(64'h0, NOP, 2'b00, w);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_mem_fetch.md
Name: inst_mem_fetch

Overview:
Parametrised, synchronous instruction memory with a valid/ready fetch port and a word-wide programming port. It replaces the reset-initialised combinational instruction ROM in the 64-bit RISC-V core and sits between the PC/fetch stage and decode. After reset it fills itself with NOPs through a self-clearing sequence. It reports misaligned and out-of-range fetches instead of returning undefined data.

Parameters:
PC_W, 64, width of the byte-addressed program counter
DEPTH, 256, number of 32-bit instruction words; must be a power of two and at least 2
IDX_W, clog2(DEPTH), word-index width; derived, not overridden
NOP_WORD, 32'h00000013, fill and fault-return value (addi x0,x0,0)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
init_done  out  1  high once the NOP fill is complete
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted when req_valid && req_ready
req_pc  in  PC_W  byte address of the instruction
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts the response
resp_instr  out  32  fetched instruction, little-endian word
resp_fault  out  2  00 ok, 01 misaligned, 10 out of range
prog_we  in  1  program-port word write enable
prog_idx  in  IDX_W  word index to write
prog_data  in  32  word to write

Behaviour:
- Reset (asynchronous, active-high) forces: state=INIT, fill counter=0, init_done=0, resp_valid=0, resp_instr=0, resp_fault=00, and req_ready=0 while in INIT.
- States are INIT, IDLE and BUSY. BUSY means a response is held in the output register.
- INIT:
  - Each cycle writes NOP_WORD to word[fill counter], then increments the counter.
  - After DEPTH cycles (counter wraps from DEPTH-1 to 0), go to IDLE and set init_done=1 on the same edge.
  - prog_we is ignored in INIT. req_ready=0.
- req_ready is 1 in IDLE, and in BUSY only when resp_ready=1. This gives a pipelined throughput of 1 fetch per cycle.
- Accept (req_valid && req_ready):
  - Next edge sets resp_valid=1 with the result and the state goes to BUSY.
  - Latency is exactly 1 cycle from the accept edge to resp_valid.
- BUSY:
  - If resp_ready=0, resp_valid, resp_instr and resp_fault hold stable.
  - If resp_ready=1 and a new accept occurs, the response is replaced on the next edge and the state stays BUSY.
  - If resp_ready=1 and there is no accept, resp_valid goes to 0 and the state goes to IDLE.
- Fault classification, evaluated on the accepted req_pc:
  - req_pc[1:0]!=0 gives fault 01.
  - Otherwise, req_pc >= DEPTH*4 (compared over the full PC_W) gives fault 10.
  - Misaligned takes priority over out of range.
  - Any fault returns resp_instr=NOP_WORD and leaves memory untouched.
- Normal fetch returns word[req_pc[IDX_W+1:2]].
- Program writes in IDLE/BUSY take effect at the edge.
- Simultaneous write and fetch to the same word: the fetch returns the OLD contents (read-before-write). The new value is visible to fetches accepted on later cycles.
- Reset asserted mid-operation aborts any pending response (resp_valid drops immediately) and restarts INIT. Memory contents are then overwritten by the fill.

Decomposition:
- Shared package inst_mem_pkg holds:
  - NOP_WORD constant
  - fault-code constants FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10
  - state encoding INIT/IDLE/BUSY
- Sub-module inst_mem_array: DEPTH x 32 storage with one synchronous write port and one synchronous read port with read-old semantics.
- Top level holds the FSM, fill counter, fault logic and the write mux (fill vs. program port).

Test Plan:
- Fill: release reset, no requests. init_done rises exactly DEPTH cycles later. Fetch of PC=0x0 and PC=0x3FC returns 0x00000013, fault 00.
- Program and fetch: write idx 0=0x00940333 and idx 1=0x413903b3, then back-to-back fetch PC=0x0, 0x4 with resp_ready=1. Required: resp on consecutive cycles with 0x00940333 then 0x413903b3, req_ready continuously 1.
- Backpressure: resp_ready=0 for 3 cycles after fetch of PC=0x4. resp_instr holds 0x413903b3, req_ready=0. With resp_ready=1 the next queued request is accepted.
- Faults: fetch PC=0x2 gives fault 01 with NOP. Fetch PC=0x400 (DEPTH=256) gives fault 10 with NOP. Fetch PC=0x1_0000_0002 gives fault 01 (priority).
- Collision: same cycle write idx 2=0xDEADBEEF and fetch PC=0x8 returns the old word. A fetch of PC=0x8 on the next cycle returns 0xDEADBEEF.
- Reset mid-stream: assert reset while resp_valid=1 and resp_ready=0. Required: resp_valid=0 and init_done=0 asynchronously, and after the refill idx 0 reads 0x00000013.
